// File: rtl/mmu_tlb_translator.sv
// rtl/mmu_tlb_translator.sv - 8-entry TLB virtual-to-physical translator ahead of the cache controller
module mmu_tlb_translator #(
  parameter int TLB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] virt_addr,
  input  logic [31:0] data_from_cpu,
  input  logic        read_req,
  input  logic        write_req,
  output logic        ready_stall,
  output logic        page_fault,
  input  logic [31:0] ptbr,
  input  logic        tlb_flush,
  output logic [31:0] phy_addr,
  output logic [31:0] data_to_cache,
  output logic        read_mem,
  output logic        write_mem,
  input  logic        cc_ready_stall,
  output logic [31:0] pte_addr,
  output logic        pte_read_req,
  input  logic [31:0] pte_data,
  input  logic        pte_ready
);
  localparam int IW = $clog2(TLB_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_WAIT, S_ISSUE, S_WAIT_CC, S_FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            va_q, va_d, data_q, data_d;
  logic                   wr_q, wr_d, cc_seen_q, cc_seen_d, flush_pend_q, flush_pend_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [TLB_ENTRIES-1:0] valid_q, valid_d;
  logic [19:0]            vpn_q [TLB_ENTRIES];
  logic [19:0]            ppn_q [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] wbit_q;

  logic        ready_stall_q, ready_stall_d, page_fault_q, page_fault_d;
  logic        read_mem_q, read_mem_d, write_mem_q, write_mem_d;
  logic        pte_read_req_q, pte_read_req_d;
  logic [31:0] phy_addr_q, phy_addr_d, data_to_cache_q, data_to_cache_d;
  logic [31:0] pte_addr_q, pte_addr_d;

  logic          hit, hit_w, has_free, fill_en, flush_now;
  logic [19:0]   hit_ppn;
  logic [IW-1:0] free_idx, fill_idx;
  logic          unused_pte_bits;

  assign unused_pte_bits = ^pte_data[11:2];

  always_comb begin
    hit     = 1'b0;
    hit_w   = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid_q[i] && vpn_q[i] == va_q[31:12]) begin
        hit     = 1'b1;
        hit_w   = wbit_q[i];
        hit_ppn = ppn_q[i];
      end
    end
    has_free = 1'b0;
    free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    va_d            = va_q;
    data_d          = data_q;
    wr_d            = wr_q;
    cc_seen_d       = cc_seen_q;
    rr_d            = rr_q;
    valid_d         = valid_q;
    flush_pend_d    = flush_pend_q | (tlb_flush && state_q != S_IDLE);
    ready_stall_d   = ready_stall_q;
    page_fault_d    = 1'b0;
    read_mem_d      = 1'b0;
    write_mem_d     = 1'b0;
    pte_read_req_d  = 1'b0;
    phy_addr_d      = phy_addr_q;
    data_to_cache_d = data_to_cache_q;
    pte_addr_d      = pte_addr_q;
    fill_en         = 1'b0;
    fill_idx        = has_free ? free_idx : rr_q;
    flush_now       = 1'b0;

    case (state_q)
      S_IDLE: begin
        flush_now = tlb_flush;
        if (read_req || write_req) begin
          va_d          = virt_addr;
          data_d        = data_from_cpu;
          wr_d          = write_req;
          ready_stall_d = 1'b1;
          state_d       = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit && (!wr_q || hit_w)) begin
          phy_addr_d      = {hit_ppn, va_q[11:0]};
          data_to_cache_d = data_q;
          read_mem_d      = !wr_q;
          write_mem_d     = wr_q;
          state_d         = S_ISSUE;
        end else if (hit) begin
          page_fault_d = 1'b1;
          state_d      = S_FAULT;
        end else begin
          pte_read_req_d = 1'b1;
          pte_addr_d     = ptbr + {10'd0, va_q[31:12], 2'b00};
          state_d        = S_WALK_REQ;
        end
      end
      S_WALK_REQ: state_d = S_WALK_WAIT;
      S_WALK_WAIT: begin
        if (pte_ready) begin
          if (!pte_data[0]) begin
            page_fault_d = 1'b1;
            state_d      = S_FAULT;
          end else begin
            fill_en           = 1'b1;
            valid_d[fill_idx] = 1'b1;
            if (!has_free) rr_d = rr_q + IW'(1);
            if (wr_q && !pte_data[1]) begin
              page_fault_d = 1'b1;
              state_d      = S_FAULT;
            end else begin
              phy_addr_d      = {pte_data[31:12], va_q[11:0]};
              data_to_cache_d = data_q;
              read_mem_d      = !wr_q;
              write_mem_d     = wr_q;
              state_d         = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: begin
        cc_seen_d = 1'b0;
        state_d   = S_WAIT_CC;
      end
      S_WAIT_CC: begin
        if (cc_ready_stall) cc_seen_d = 1'b1;
        else if (cc_seen_q) state_d = S_IDLE;
      end
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Leaving a busy state: drop the cache-side request and apply any deferred flush.
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      ready_stall_d   = 1'b0;
      phy_addr_d      = '0;
      data_to_cache_d = '0;
      flush_now       = flush_pend_q | tlb_flush;
      flush_pend_d    = 1'b0;
    end
    if (flush_now) begin
      valid_d = '0;
      rr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      va_q            <= '0;
      data_q          <= '0;
      wr_q            <= 1'b0;
      cc_seen_q       <= 1'b0;
      flush_pend_q    <= 1'b0;
      rr_q            <= '0;
      valid_q         <= '0;
      ready_stall_q   <= 1'b0;
      page_fault_q    <= 1'b0;
      read_mem_q      <= 1'b0;
      write_mem_q     <= 1'b0;
      pte_read_req_q  <= 1'b0;
      phy_addr_q      <= '0;
      data_to_cache_q <= '0;
      pte_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      va_q            <= va_d;
      data_q          <= data_d;
      wr_q            <= wr_d;
      cc_seen_q       <= cc_seen_d;
      flush_pend_q    <= flush_pend_d;
      rr_q            <= rr_d;
      valid_q         <= valid_d;
      ready_stall_q   <= ready_stall_d;
      page_fault_q    <= page_fault_d;
      read_mem_q      <= read_mem_d;
      write_mem_q     <= write_mem_d;
      pte_read_req_q  <= pte_read_req_d;
      phy_addr_q      <= phy_addr_d;
      data_to_cache_q <= data_to_cache_d;
      pte_addr_q      <= pte_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      vpn_q[fill_idx]  <= va_q[31:12];
      ppn_q[fill_idx]  <= pte_data[31:12];
      wbit_q[fill_idx] <= pte_data[1];
    end
  end

  assign ready_stall   = ready_stall_q;
  assign page_fault    = page_fault_q;
  assign read_mem      = read_mem_q;
  assign write_mem     = write_mem_q;
  assign pte_read_req  = pte_read_req_q;
  assign phy_addr      = phy_addr_q;
  assign data_to_cache = data_to_cache_q;
  assign pte_addr      = pte_addr_q;
endmodule
